// File: rtl/adfifo_uart_sched_pkg.sv
// Shared definitions for the AD-FIFO to UART drain scheduler:
// state encoding, line terminator bytes and the default inter-byte gap.
package adfifo_uart_sched_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_RD   = 4'd1,
    S_LAT  = 4'd2,
    S_SEND = 4'd3,
    S_ACK  = 4'd4,
    S_BUSY = 4'd5,
    S_GAP  = 4'd6,
    S_CSUM = 4'd7
  } state_e;

  localparam logic [7:0]  LF = 8'h0a;
  localparam logic [7:0]  CR = 8'h0d;

  localparam logic [15:0] DEFAULT_GAP_CYCLES = 16'd0;

endpackage

// File: rtl/adfifo_uart_sched_gap_timer.sv
// Inter-byte gap timer: 16-bit counter that is cleared on entry to the gap
// state, counts while the gap state is active and reports when the
// programmed number of idle cycles has been reached.
module adfifo_gap_timer
  import adfifo_uart_sched_pkg::*;
#(
  parameter logic [15:0] GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic run_i,
  output logic done_o
);

  logic [15:0] count_q;

  assign done_o = (count_q >= GAP_CYCLES);

  // Counter clears on request, then advances while running until done.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= 16'd0;
    end else if (clear_i) begin
      count_q <= 16'd0;
    end else if (run_i && !done_o) begin
      count_q <= count_q + 16'd1;
    end
  end

endmodule

// File: rtl/adfifo_uart_sched.sv
// Drain scheduler: pops one byte at a time from the AD sample FIFO and hands
// it to the UART with a start/busy handshake, followed by a programmable
// idle gap. Optional per-line checksum byte after every data LF is built
// only when the macro CSUM_ADD_EN is defined.
module adfifo_uart_sched
  import adfifo_uart_sched_pkg::*;
#(
  parameter logic [15:0] GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tx_en,
  input  logic        empty,
  input  logic [7:0]  q,
  output logic        rdreq,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic [15:0] sent_cnt,
  output logic [3:0]  SS_state
);

  state_e      state_q, state_d;
  logic [7:0]  tx_data_q;
  logic [15:0] sent_cnt_q;
  logic        gap_done;
  logic        byte_done;

  // A byte is complete on the cycle the UART drops busy while we wait on it.
  assign byte_done = (state_q == S_BUSY) && !tx_busy;

  adfifo_gap_timer #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_gap_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (byte_done),
    .run_i   (state_q == S_GAP),
    .done_o  (gap_done)
  );

`ifdef CSUM_ADD_EN
  logic [7:0] line_sum_q;
  logic       csum_flag_q;

  // Running line sum of completed data bytes and the "this is a checksum" flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      line_sum_q  <= 8'd0;
      csum_flag_q <= 1'b0;
    end else begin
      if (state_q == S_LAT) begin
        csum_flag_q <= 1'b0;
      end
      if (state_q == S_CSUM) begin
        csum_flag_q <= 1'b1;
        line_sum_q  <= 8'd0;
      end
      if (byte_done && !csum_flag_q && (tx_data_q != LF)) begin
        line_sum_q <= line_sum_q + tx_data_q;
      end
    end
  end
`endif

  // Next-state logic; tx_en is only consulted when idle so a byte in flight
  // (and any checksum it triggers) always completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (tx_en && !empty) state_d = S_RD;
      S_RD:   state_d = S_LAT;
      S_LAT:  state_d = S_SEND;
      S_SEND: state_d = S_ACK;
      S_ACK:  state_d = S_BUSY;
      S_BUSY: if (!tx_busy) state_d = S_GAP;
      S_GAP: begin
        if (gap_done) begin
`ifdef CSUM_ADD_EN
          if ((tx_data_q == LF) && !csum_flag_q) state_d = S_CSUM;
          else                                   state_d = S_IDLE;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef CSUM_ADD_EN
      S_CSUM: state_d = S_SEND;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State register, transmit data holding register and sent-byte counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      tx_data_q  <= 8'd0;
      sent_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_LAT) begin
        tx_data_q <= q;
      end
`ifdef CSUM_ADD_EN
      if (state_q == S_CSUM) begin
        tx_data_q <= line_sum_q;
      end
`endif
      if (byte_done) begin
        sent_cnt_q <= sent_cnt_q + 16'd1;
      end
    end
  end

  assign rdreq    = (state_q == S_RD) && !empty;
  assign tx_start = (state_q == S_SEND);
  assign tx_data  = tx_data_q;
  assign sent_cnt = sent_cnt_q;
  assign SS_state = state_q;

endmodule

// File: tb/tb_adfifo_uart_sched.sv
// Self-checking bench for adfifo_uart_sched. A queue-based FIFO model and a
// counting UART model surround the DUT; expected output bytes come from a
// stream-level reference of the line/checksum rules (CSUM_ADD_EN aware).
module tb_adfifo_uart_sched;

  localparam logic [15:0] TB_GAP = 16'd5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tx_en = 1'b0;
  logic        empty = 1'b1;
  logic [7:0]  q = 8'd0;
  logic        tx_busy = 1'b0;
  logic        rdreq, tx_start;
  logic [7:0]  tx_data;
  logic [15:0] sent_cnt;
  logic [3:0]  SS_state;

  logic [7:0] fifo_q[$];
  logic [7:0] out_log[$];
  logic [7:0] exp_q[$];

  int cyc = 0;
  int rd_cnt = 0, start_cnt = 0, rd_wide = 0, start_wide = 0;
  int empty_fall_cyc = 0, busy_fall_cyc = 0, last_rd_cyc = 0, last_start_cyc = 0;
  int last_gap_meas = 0;
  int busy_cnt = 0, busy_len = 10;
  bit rd_pend = 0, start_pend = 0, prev_rd = 0, prev_start = 0;
  bit prev_empty = 1, prev_busy = 0;
  int n_cmp = 0, n_fail = 0;
  logic [7:0] ref_sum = 8'd0;
  int exp_sent = 0;

  adfifo_uart_sched #(
    .GAP_CYCLES(TB_GAP)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .tx_en    (tx_en),
    .empty    (empty),
    .q        (q),
    .rdreq    (rdreq),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .sent_cnt (sent_cnt),
    .SS_state (SS_state)
  );

  always #10 clk = ~clk;

  // FIFO and UART models react on the active edge to requests seen mid-cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_pend && fifo_q.size() > 0) q <= fifo_q.pop_front();
    empty <= (fifo_q.size() == 0);
    if (start_pend) begin
      busy_cnt = busy_len;
      tx_busy <= 1'b1;
    end else if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
      if (busy_cnt == 0) tx_busy <= 1'b0;
    end
  end

  // Mid-cycle monitor: logs handshakes, pulse widths and event timestamps.
  always @(negedge clk) begin
    rd_pend = rdreq;
    start_pend = tx_start;
    if (prev_empty && !empty) empty_fall_cyc = cyc;
    if (prev_busy && !tx_busy) busy_fall_cyc = cyc;
    if (rdreq) begin
      rd_cnt++;
      last_rd_cyc = cyc;
      if (prev_rd) rd_wide++;
    end
    if (tx_start) begin
      out_log.push_back(tx_data);
      start_cnt++;
      last_start_cyc = cyc;
      last_gap_meas = cyc - busy_fall_cyc;
      if (prev_start) start_wide++;
    end
    prev_rd = rdreq;
    prev_start = tx_start;
    prev_empty = empty;
    prev_busy = tx_busy;
  end

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  // Reference: every data byte goes out; after a data LF the line sum follows.
  task automatic exp_push(input logic [7:0] b);
    exp_q.push_back(b);
    exp_sent++;
`ifdef CSUM_ADD_EN
    if (b == 8'h0a) begin
      exp_q.push_back(ref_sum);
      exp_sent++;
    end
`endif
    ref_sum = (b == 8'h0a) ? 8'd0 : ref_sum + b;
  endtask

  task automatic wait_drain(output bit ok);
    int stable;
    stable = 0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (out_log.size() >= exp_q.size() && fifo_q.size() == 0 && empty &&
          !tx_busy && SS_state == 4'd0) stable++;
      else stable = 0;
      if (stable >= 4) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tx_en = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (rdreq !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rdreq: got %b expected 0", rdreq); end
    n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tx_start: got %b expected 0", tx_start); end
    n_cmp++; if (tx_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_tx_data: got %h expected 00", tx_data); end
    n_cmp++; if (sent_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_sent_cnt: got %0d expected 0", sent_cnt); end
    n_cmp++; if (SS_state !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_state: got %0d expected 0", SS_state); end
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (SS_state !== 4'd0) begin n_fail++; $display("[TB] FAIL idle_after_reset: got %0d expected 0", SS_state); end
  endtask

  task automatic test_two_bytes;
    int rd0, base;
    bit ok;
    rd0 = rd_cnt;
    base = exp_q.size();
    busy_len = 10;
    tx_en = 1'b1;
    push(8'h12); exp_push(8'h12);
    push(8'h34); exp_push(8'h34);
    wait_drain(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("[TB] FAIL two_drain: got timeout expected idle"); end
    n_cmp++; if (rd_cnt - rd0 != 2) begin n_fail++; $display("[TB] FAIL two_rdreq: got %0d expected 2", rd_cnt - rd0); end
    n_cmp++; if (out_log.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL two_len: got %0d expected %0d", out_log.size(), exp_q.size()); end
    for (int i = base; i < exp_q.size() && i < out_log.size(); i++) begin
      n_cmp++;
      if (out_log[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL two_byte%0d: got %h expected %h", i, out_log[i], exp_q[i]); end
    end
    n_cmp++; if (sent_cnt !== exp_sent[15:0]) begin n_fail++; $display("[TB] FAIL two_sent_cnt: got %0d expected %0d", sent_cnt, exp_sent); end
    n_cmp++; if (empty !== 1'b1 || SS_state !== 4'd0) begin n_fail++; $display("[TB] FAIL two_idle: got state %0d empty %b expected 0 1", SS_state, empty); end
  endtask

  task automatic test_latency;
    bit ok;
    push(8'h5a); exp_push(8'h5a);
    wait_drain(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("[TB] FAIL lat_drain: got timeout expected idle"); end
    n_cmp++; if (last_rd_cyc - empty_fall_cyc != 1) begin n_fail++; $display("[TB] FAIL lat_rdreq: got %0d expected 1", last_rd_cyc - empty_fall_cyc); end
    n_cmp++; if (last_start_cyc - empty_fall_cyc != 3) begin n_fail++; $display("[TB] FAIL lat_start: got %0d expected 3", last_start_cyc - empty_fall_cyc); end
    n_cmp++; if (rd_wide != 0 || start_wide != 0) begin n_fail++; $display("[TB] FAIL lat_pulse_width: got %0d/%0d expected 0/0", rd_wide, start_wide); end
    n_cmp++; if (out_log.size() == 0 || out_log[out_log.size()-1] !== 8'h5a) begin n_fail++; $display("[TB] FAIL lat_byte: got size %0d expected last 5a", out_log.size()); end
  endtask

  task automatic test_gap;
    int s0;
    bit ok;
    s0 = start_cnt;
    push(8'h21); exp_push(8'h21);
    push(8'h22); exp_push(8'h22);
    wait_drain(ok);
    n_cmp++; if (!ok || start_cnt - s0 != 2) begin n_fail++; $display("[TB] FAIL gap_starts: got %0d expected 2", start_cnt - s0); end
    // The gap state spans GAP+1 cycles, then IDLE, RD, LAT precede SEND.
    n_cmp++; if (last_gap_meas != int'(TB_GAP) + 5) begin n_fail++; $display("[TB] FAIL gap_busy_to_start: got %0d expected %0d", last_gap_meas, int'(TB_GAP) + 5); end
    n_cmp++; if (sent_cnt !== exp_sent[15:0]) begin n_fail++; $display("[TB] FAIL gap_sent_cnt: got %0d expected %0d", sent_cnt, exp_sent); end
  endtask

  task automatic test_tx_en_drop;
    int rd0, s0, base, to;
    bit ok;
    rd0 = rd_cnt;
    s0 = start_cnt;
    base = exp_q.size();
    push(8'h41); exp_push(8'h41);
    push(8'h42); exp_push(8'h42);
    push(8'h43); exp_push(8'h43);
    to = 0;
    while (!tx_busy && to < 200) begin @(negedge clk); to++; end
    n_cmp++; if (!tx_busy) begin n_fail++; $display("[TB] FAIL drop_busy_wait: got timeout expected busy"); end
    @(negedge clk);
    tx_en = 1'b0;
    repeat (40) @(negedge clk);
    n_cmp++; if (rd_cnt - rd0 != 1) begin n_fail++; $display("[TB] FAIL drop_rdreq: got %0d expected 1", rd_cnt - rd0); end
    n_cmp++; if (start_cnt - s0 != 1) begin n_fail++; $display("[TB] FAIL drop_starts: got %0d expected 1", start_cnt - s0); end
    n_cmp++; if (fifo_q.size() != 2) begin n_fail++; $display("[TB] FAIL drop_remaining: got %0d expected 2", fifo_q.size()); end
    n_cmp++; if (sent_cnt !== 16'(exp_sent - 2)) begin n_fail++; $display("[TB] FAIL drop_sent_cnt: got %0d expected %0d", sent_cnt, exp_sent - 2); end
    n_cmp++; if (SS_state !== 4'd0) begin n_fail++; $display("[TB] FAIL drop_parked: got %0d expected 0", SS_state); end
    tx_en = 1'b1;
    wait_drain(ok);
    n_cmp++; if (!ok || rd_cnt - rd0 != 3) begin n_fail++; $display("[TB] FAIL drop_resume_rdreq: got %0d expected 3", rd_cnt - rd0); end
    n_cmp++; if (out_log.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL drop_len: got %0d expected %0d", out_log.size(), exp_q.size()); end
    for (int i = base; i < exp_q.size() && i < out_log.size(); i++) begin
      n_cmp++;
      if (out_log[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL drop_byte%0d: got %h expected %h", i, out_log[i], exp_q[i]); end
    end
    n_cmp++; if (sent_cnt !== exp_sent[15:0]) begin n_fail++; $display("[TB] FAIL drop_sent_final: got %0d expected %0d", sent_cnt, exp_sent); end
  endtask

  task automatic test_reset_busy;
    int rd0, base, to;
    bit ok;
    rd0 = rd_cnt;
    base = exp_q.size();
    busy_len = 10;
    push(8'h55);
    push(8'h66);
    to = 0;
    while (!tx_busy && to < 200) begin @(negedge clk); to++; end
    n_cmp++; if (!tx_busy) begin n_fail++; $display("[TB] FAIL rst_busy_wait: got timeout expected busy"); end
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (SS_state !== 4'd0) begin n_fail++; $display("[TB] FAIL rst_state: got %0d expected 0", SS_state); end
    n_cmp++; if (rdreq !== 1'b0 || tx_start !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_strobes: got %b%b expected 00", rdreq, tx_start); end
    n_cmp++; if (tx_data !== 8'h00) begin n_fail++; $display("[TB] FAIL rst_tx_data: got %h expected 00", tx_data); end
    n_cmp++; if (sent_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL rst_sent_cnt: got %0d expected 0", sent_cnt); end
    reset_n = 1'b1;
    // The abandoned byte was already handed to the UART but never counted.
    exp_q.push_back(8'h55);
    ref_sum = 8'd0;
    exp_sent = 0;
    exp_push(8'h66);
    wait_drain(ok);
    n_cmp++; if (!ok || rd_cnt - rd0 != 2) begin n_fail++; $display("[TB] FAIL rst_rdreq: got %0d expected 2", rd_cnt - rd0); end
    n_cmp++; if (out_log.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL rst_len: got %0d expected %0d", out_log.size(), exp_q.size()); end
    for (int i = base; i < exp_q.size() && i < out_log.size(); i++) begin
      n_cmp++;
      if (out_log[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL rst_byte%0d: got %h expected %h", i, out_log[i], exp_q[i]); end
    end
    n_cmp++; if (sent_cnt !== 16'd1) begin n_fail++; $display("[TB] FAIL rst_sent_after: got %0d expected 1", sent_cnt); end
  endtask

  task automatic test_csum;
    logic [7:0] pat [6];
    int base;
    bit ok;
    pat = '{8'h10, 8'h20, 8'h0d, 8'h0a, 8'h05, 8'h0a};
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    ref_sum = 8'd0;
    exp_sent = 0;
    base = exp_q.size();
    foreach (pat[i]) begin
      push(pat[i]);
      exp_push(pat[i]);
    end
    wait_drain(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("[TB] FAIL csum_drain: got timeout expected idle"); end
    n_cmp++; if (out_log.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL csum_len: got %0d expected %0d", out_log.size(), exp_q.size()); end
    for (int i = base; i < exp_q.size() && i < out_log.size(); i++) begin
      n_cmp++;
      if (out_log[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL csum_byte%0d: got %h expected %h", i - base, out_log[i], exp_q[i]); end
    end
    n_cmp++; if (sent_cnt !== exp_sent[15:0]) begin n_fail++; $display("[TB] FAIL csum_sent_cnt: got %0d expected %0d", sent_cnt, exp_sent); end
  endtask

  task automatic test_random;
    int rd0, base, n;
    bit ok;
    logic [7:0] b;
    rd0 = rd_cnt;
    base = exp_q.size();
    busy_len = $urandom_range(1, 12);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      tx_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) begin
        b = ($urandom_range(0, 3) == 0) ? 8'h0a : 8'($urandom_range(0, 255));
        push(b);
        exp_push(b);
        n++;
      end
    end
    tx_en = 1'b1;
    wait_drain(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("[TB] FAIL rand_drain: got timeout expected idle"); end
    n_cmp++; if (rd_cnt - rd0 != 40) begin n_fail++; $display("[TB] FAIL rand_rdreq: got %0d expected 40", rd_cnt - rd0); end
    n_cmp++; if (out_log.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL rand_len: got %0d expected %0d", out_log.size(), exp_q.size()); end
    for (int i = base; i < exp_q.size() && i < out_log.size(); i++) begin
      n_cmp++;
      if (out_log[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL rand_byte%0d: got %h expected %h", i - base, out_log[i], exp_q[i]); end
    end
    n_cmp++; if (sent_cnt !== exp_sent[15:0]) begin n_fail++; $display("[TB] FAIL rand_sent_cnt: got %0d expected %0d", sent_cnt, exp_sent); end
    n_cmp++; if (rd_wide != 0 || start_wide != 0) begin n_fail++; $display("[TB] FAIL rand_pulse_width: got %0d/%0d expected 0/0", rd_wide, start_wide); end
  endtask

  // Scenario sequence, ending in the single summary line.
  initial begin
    test_reset;
    test_two_bytes;
    test_latency;
    test_gap;
    test_tx_en_drop;
    test_reset_busy;
    test_csum;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
